// File: rtl/jtag_shift_engine_pkg.sv
// Shared definitions for the JTAG shift engine: engine states and field widths.
package jtag_shift_engine_pkg;

    localparam int PRESCALAR_W    = 8;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

endpackage

// File: rtl/jtag_shift_engine_tck_divider.sv
// TCK phase timer: counts clk cycles within one TCK half-period and flags the last one.
module jtag_shift_engine_tck_divider
    import jtag_shift_engine_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   restart,
    input  logic [PRESCALAR_W-1:0] limit,
    output logic                   phase_done
);

    logic [PRESCALAR_W-1:0] cnt;

    // Restart on every phase change, so the count never exceeds limit and cannot wrap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign phase_done = en && (cnt == limit);

endmodule

// File: rtl/jtag_shift_engine.sv
// Bit-serial JTAG master: shifts TDI/TMS out LSB first and captures TDO into rd_data.
// Define JTAG_SHIFT_ENGINE_LATE_SAMPLE_EN to sample TDO on the last clk cycle of TCK high.
module jtag_shift_engine
    import jtag_shift_engine_pkg::*;
#(
    parameter logic IDLE_VALUE = 1'b0,
    parameter int   DATA_W     = DEFAULT_DATA_W,
    localparam int  LEN_W      = $clog2(DATA_W)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [PRESCALAR_W-1:0] prescalar,
    input  logic [LEN_W-1:0]       len,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [DATA_W-1:0]      stb_data,
    input  logic                   start,
    output logic                   ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   tck,
    output logic                   tdi,
    output logic                   tms,
    input  logic                   tdo
);

    state_t                 state;
    logic [PRESCALAR_W-1:0] pre_sh;
    logic [LEN_W-1:0]       len_sh;
    logic [DATA_W-1:0]      wr_sh;
    logic [DATA_W-1:0]      stb_sh;
    logic [LEN_W-1:0]       bit_idx;
    logic [LEN_W-1:0]       nxt_idx;
    logic                   accept;
    logic                   phase_done;

    assign accept  = ready && start;
    assign nxt_idx = bit_idx + 1'b1;

    jtag_shift_engine_tck_divider u_div (
        .clk        (clk),
        .rstn       (rstn),
        .en         (state != ST_IDLE),
        .restart    (accept || phase_done),
        .limit      (pre_sh),
        .phase_done (phase_done)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            tck     <= IDLE_VALUE;
            tdi     <= 1'b0;
            tms     <= 1'b0;
            rd_data <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pre_sh  <= prescalar;
                        len_sh  <= len;
                        wr_sh   <= wr_data;
                        stb_sh  <= stb_data;
                        rd_data <= '0;
                        bit_idx <= '0;
                        tdi     <= wr_data[0];
                        tms     <= stb_data[0];
                        tck     <= 1'b0;
                        ready   <= 1'b0;
                        state   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (phase_done) begin
                        tck   <= 1'b1;
                        state <= ST_HIGH;
`ifndef JTAG_SHIFT_ENGINE_LATE_SAMPLE_EN
                        rd_data[bit_idx] <= tdo;
`endif
                    end
                end
                ST_HIGH: begin
                    if (phase_done) begin
`ifdef JTAG_SHIFT_ENGINE_LATE_SAMPLE_EN
                        rd_data[bit_idx] <= tdo;
`endif
                        if (bit_idx == len_sh) begin
                            tck   <= IDLE_VALUE;
                            ready <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            bit_idx <= nxt_idx;
                            tdi     <= wr_sh[nxt_idx];
                            tms     <= stb_sh[nxt_idx];
                            tck     <= 1'b0;
                            state   <= ST_LOW;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    tck   <= IDLE_VALUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Scoreboard bench for jtag_shift_engine: directed transfers, monitor checks each completion.
module tb_jtag_shift_engine;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  prescalar = '0;
    logic [4:0]  len = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] stb_data = '0;
    logic        start = 1'b0;
    logic        ready;
    logic [31:0] rd_data;
    logic        tck, tdi, tms;
    logic        tdo;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rd;
        int          busy;
        int          nbits;
        logic [31:0] tdi_bits;
        logic [31:0] tms_bits;
        int          phase;
        bit          abort;
    } exp_t;

    exp_t sb[$];

    int          tdo_mode = 0;
    logic [31:0] pat = '0;

    bit          in_txn = 0;
    bit          prev_tck = 0;
    int          busy, rises, falls, cur_run, hi_age;
    int          hi_min, hi_max, lo_min, lo_max;
    logic [31:0] cap_tdi, cap_tms;

    assign tdo = (tdo_mode == 1) ? tdi :
                 (tdo_mode == 2) ? (tck && hi_age >= 1) : pat[falls[4:0]];

    jtag_shift_engine dut (
        .clk       (clk),
        .rstn      (rstn),
        .prescalar (prescalar),
        .len       (len),
        .wr_data   (wr_data),
        .stb_data  (stb_data),
        .start     (start),
        .ready     (ready),
        .rd_data   (rd_data),
        .tck       (tck),
        .tdi       (tdi),
        .tms       (tms),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic close_run();
        if (prev_tck) begin
            if (cur_run < hi_min) hi_min = cur_run;
            if (cur_run > hi_max) hi_max = cur_run;
        end else begin
            if (cur_run < lo_min) lo_min = cur_run;
            if (cur_run > lo_max) lo_max = cur_run;
        end
    endtask

    // Monitor: tracks each busy window and compares against the scoreboard on completion
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (in_txn) begin
            if (ready === 1'b1) begin
                in_txn = 0;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.abort) begin
                        check("abort_rd", rd_data, 32'd0);
                        check("abort_tck", {31'd0, tck}, 32'd0);
                        check("abort_tdi", {31'd0, tdi}, 32'd0);
                        check("abort_tms", {31'd0, tms}, 32'd0);
                    end else begin
                        close_run();
                        check("rd_data", rd_data, e.rd);
                        check("busy_cycles", busy, e.busy);
                        check("tck_rises", rises, e.nbits);
                        check("tdi_bits", cap_tdi, e.tdi_bits);
                        check("tms_bits", cap_tms, e.tms_bits);
                        check("tck_high_min", hi_min, e.phase);
                        check("tck_high_max", hi_max, e.phase);
                        check("tck_low_min", lo_min, e.phase);
                        check("tck_low_max", lo_max, e.phase);
                        check("tck_idle", {31'd0, tck}, 32'd0);
                    end
                end
            end else begin
                busy++;
                if (tck !== prev_tck) begin
                    close_run();
                    cur_run = 1;
                    if (tck === 1'b1) begin
                        if (rises < 32) begin
                            cap_tdi[rises] = tdi;
                            cap_tms[rises] = tms;
                        end
                        rises++;
                        hi_age = 0;
                    end else begin
                        falls++;
                    end
                end else begin
                    cur_run++;
                    if (tck === 1'b1) hi_age++;
                end
            end
        end else if (ready === 1'b0) begin
            in_txn  = 1;
            busy    = 1;
            rises   = 0;
            falls   = 0;
            cur_run = 1;
            hi_age  = 0;
            hi_min  = 9999; hi_max = 0;
            lo_min  = 9999; lo_max = 0;
            cap_tdi = '0;
            cap_tms = '0;
        end
        prev_tck = (tck === 1'b1);
    end

    task automatic push_exp(input int p, input int l, input logic [31:0] wr,
                            input logic [31:0] stb, input logic [31:0] rd);
        exp_t e;
        logic [31:0] mask;
        mask       = (l == 31) ? 32'hFFFF_FFFF : ((32'd1 << (l + 1)) - 32'd1);
        e.rd       = rd;
        e.busy     = 2 * (l + 1) * (p + 1);
        e.nbits    = l + 1;
        e.tdi_bits = wr & mask;
        e.tms_bits = stb & mask;
        e.phase    = p + 1;
        e.abort    = 0;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        while (ready !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic issue(input int p, input int l, input logic [31:0] wr, input logic [31:0] stb);
        @(negedge clk);
        prescalar = p[7:0];
        len       = l[4:0];
        wr_data   = wr;
        stb_data  = stb;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_txn(input int p, input int l, input logic [31:0] wr, input logic [31:0] stb,
                           input int mode, input logic [31:0] pattern, input logic [31:0] rd);
        push_exp(p, l, wr, stb, rd);
        tdo_mode = mode;
        pat      = pattern;
        issue(p, l, wr, stb);
        wait_ready(2 * (l + 1) * (p + 1) + 10);
    endtask

    initial begin
        exp_t ab;
        logic [31:0] late_exp;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_tck", {31'd0, tck}, 32'd0);
        check("rst_tdi", {31'd0, tdi}, 32'd0);
        check("rst_tms", {31'd0, tms}, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // basic: tdo 1,0,1,1 per bit
        run_txn(0, 3, 32'hA, 32'h8, 0, 32'hD, 32'h0000_000D);
        // full-width loopback
        run_txn(0, 31, 32'hDEAD_BEEF, 32'h8000_0001, 1, 32'h0, 32'hDEAD_BEEF);
        // divider prescalar=2, single bit
        run_txn(2, 0, 32'h1, 32'h1, 0, 32'h1, 32'h1);
        // slowest divider
        run_txn(255, 1, 32'h2, 32'h1, 1, 32'h0, 32'h2);

        // start during busy with changed data must be ignored
        push_exp(1, 3, 32'h5, 32'h3, 32'h5);
        tdo_mode = 1;
        issue(1, 3, 32'h5, 32'h3);
        @(negedge clk);
        wr_data = 32'hFFFF_FFFF;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_ready(40);

        // reset abort at busy cycle 5 of a len=7 transfer
        ab = '{rd: 32'd0, busy: 0, nbits: 0, tdi_bits: 32'd0, tms_bits: 32'd0, phase: 0, abort: 1'b1};
        sb.push_back(ab);
        tdo_mode = 1;
        issue(0, 7, 32'hFF, 32'hFF);
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        repeat (2) @(negedge clk);
        run_txn(0, 7, 32'h5A, 32'h81, 1, 32'h0, 32'h5A);

        // tdo rises one cycle after tck: late sampling sees the new value
`ifdef JTAG_SHIFT_ENGINE_LATE_SAMPLE_EN
        late_exp = 32'h1;
`else
        late_exp = 32'h0;
`endif
        run_txn(3, 0, 32'h1, 32'h0, 2, 32'h0, late_exp);

        repeat (4) @(negedge clk);
        check("sb_left", sb.size(), 32'd0);
        check("final_ready", {31'd0, ready}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jtag_shift_engine.md
Name: jtag_shift_engine

Overview:
- Bit-serial JTAG master shift engine.
- Consumes the register values, start strobe and prescaler from the ControlPort JTAG wrapper.
- Produces TCK/TDI/TMS, captures TDO, and returns ready plus up to 32 received bits.
- Sits between the ControlPort register block and the CPLD JTAG pins, in the same clock domain as the wrapper.

Parameters:
IDLE_VALUE, 1'b0, TCK level driven while idle/after reset
DATA_W, 32, maximum bits per transaction (len width = clog2(DATA_W))

Ports:
clk  in  1  ControlPort clock; all logic on rising edge
rstn  in  1  synchronous active-low reset
prescalar  in  8  TCK half-period = prescalar+1 clk cycles
len  in  5  number of bits minus 1
wr_data  in  32  TDI bits, bit 0 shifted first
stb_data  in  32  TMS bits, bit 0 shifted first
start  in  1  single-cycle transaction request
ready  out  1  high when idle and able to accept start
rd_data  out  32  captured TDO bits, bit i = i-th sampled bit
tck  out  1  JTAG clock
tdi  out  1  JTAG data out
tms  out  1  JTAG mode select
tdo  in  1  JTAG data in

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE; tck=IDLE_VALUE; tdi=0; tms=0; rd_data=0; ready=1 after that edge.
  - All outputs are registered.
- States:
  - IDLE: ready=1, tck=IDLE_VALUE. Start sampled with ready=1 starts a transaction:
    - latch prescalar, len, wr_data, stb_data into shadow registers;
    - clear rd_data to 0; bit_idx=0; divider counter=0;
    - go to LOW. ready drops the next cycle.
  - LOW: tck=0; tdi=wr_sh[bit_idx]; tms=stb_sh[bit_idx], both driven from the LOW entry edge. After prescalar+1 cycles, go to HIGH.
  - HIGH: tck=1. At the edge entering HIGH, rd_data[bit_idx] <= tdo. After prescalar+1 cycles:
    - if bit_idx==len_sh: go to IDLE (tck=IDLE_VALUE, ready=1 from that edge);
    - else bit_idx+1 and go to LOW.
- Timing:
  - Busy duration = 2*(len+1)*(prescalar+1) cycles from the cycle after start to ready re-asserting.
  - TCK frequency = f_clk/(2*(prescalar+1)).
- Input handling:
  - start while ready=0 is ignored, with no queueing.
  - Input changes during busy have no effect because shadow registers are used.
- Output hold:
  - tdi/tms hold their last driven values in IDLE.
  - rd_data holds until the next accepted start.
  - Bits above len_sh in rd_data remain 0.
- rstn low mid-transaction: abort on that edge, with every output returning to its reset value. No partial rd_data is preserved.
- Boundaries:
  - prescalar=0 gives 1-cycle phases.
  - prescalar=255 gives 256-cycle phases; the divider counter is 8 bits and does not overflow.
  - len=31 shifts all 32 bits; bit_idx is 5 bits and never wraps.
- start coincident with rstn=0: reset wins.

Optional Feature:
- Macro: JTAG_SHIFT_ENGINE_LATE_SAMPLE_EN
- Defined: TDO is sampled on the last clk cycle of HIGH, just before the falling edge. This tolerates long board TDO delay.
- Undefined: TDO is sampled at the edge entering HIGH, per the Behaviour section.
- Busy duration is unchanged in both cases.

Decomposition:
- Shared header jtag_shift_engine_utils.vh holds:
  - state encodings (IDLE, LOW, HIGH);
  - PRESCALAR_W=8, LEN_W=5, DATA_W=32.
- The ControlPort wrapper includes the same header for width consistency.
- Natural sub-module: jtag_tck_divider.
  - Loadable 8-bit counter with phase_done pulse.
  - Runs when enabled, restarts on phase entry.

Test Plan:
- Basic transfer:
  - Stimulus: after reset, prescalar=0, len=3, wr_data=0xA, stb_data=0x8, tdo driven 1,0,1,1 on successive rising TCKs.
  - Response: tdi 0,1,0,1; tms 0,0,0,1; rd_data=0x0000000D; ready low for exactly 8 cycles.
- Full-width loopback:
  - Stimulus: prescalar=0, len=31, wr_data=0xDEADBEEF, tdo tied to tdi.
  - Response: rd_data=0xDEADBEEF; 64 busy cycles; 32 TCK rising edges.
- Divider check:
  - Stimulus: prescalar=2, len=0.
  - Response: tck low 3 cycles, high 3 cycles; ready back after 6 cycles; tck=IDLE_VALUE afterwards.
- Busy-time robustness:
  - Stimulus: start pulsed again 2 cycles after an accepted start, with wr_data changed to 0xFFFFFFFF.
  - Response: second start ignored; shifted bits follow the original latched data.
- Reset abort:
  - Stimulus: rstn=0 at busy cycle 5 of a len=7 transfer.
  - Response: the next edge gives tck=IDLE_VALUE, tdi=tms=0, rd_data=0, ready=1. A new start afterwards completes normally.
- Late-sample feature:
  - Stimulus: with JTAG_SHIFT_ENGINE_LATE_SAMPLE_EN defined, prescalar=3, tdo changes 1 cycle after tck rises.
  - Response: rd_data captures the post-change value. With the macro undefined, rd_data captures the pre-change value.
